// File: rtl/axi_master_bridge_if.sv
// AXI4 bus bundle between the core-side bridge (master) and the interconnect (slave).
// Only the channels the bridge needs are carried; lock/cache/prot/qos are left to the fabric.
interface axi_master_bridge_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [3:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;

    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    logic [ID_W-1:0]     ARID;
    logic [ADDR_W-1:0]   ARADDR;
    logic [3:0]          ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARVALID;
    logic                ARREADY;

    logic [ID_W-1:0]     RID;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi_master_bridge.sv
// Core memory port -> AXI4 master: single-beat writes, INCR read bursts of 1-16 words,
// one outstanding transaction, every AXI output driven from a register.
module axi_master_bridge #(
    parameter int              ID_W      = 4,
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter logic [ID_W-1:0] MASTER_ID = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_write_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [3:0]          req_len_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_wstrb_i,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_last_o,
    output logic                rsp_err_o,
    axi_master_bridge_if.master axi
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B} state_e;

    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

    state_e              state_q;
    logic                req_ready_q;
    logic                arvalid_q, rready_q;
    logic                awvalid_q, wvalid_q, bready_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          len_q, cnt_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                rsp_valid_q, rsp_last_q, rsp_err_q;
    logic [DATA_W-1:0]   rsp_rdata_q;

    logic rd_err_d, wr_err_d, aw_done_d, w_done_d;

    // A channel counts as done once its VALID has dropped or it handshakes this cycle.
    always_comb begin
        rd_err_d  = (axi.RRESP != 2'b00) || (axi.RID != MASTER_ID) ||
                    (axi.RLAST != (cnt_q == len_q));
        wr_err_d  = (axi.BRESP != 2'b00) || (axi.BID != MASTER_ID);
        aw_done_d = !awvalid_q || axi.AWREADY;
        w_done_d  = !wvalid_q  || axi.WREADY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= req_addr_i & ADDR_MASK;
                        len_q       <= req_write_i ? 4'd0 : req_len_i;
                        wdata_q     <= req_wdata_i;
                        wstrb_q     <= req_wstrb_i;
                        cnt_q       <= '0;
                        if (req_write_i) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_AW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_A;
                        end
                    end
                end
                RD_A: begin
                    if (axi.ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_D;
                    end
                end
                RD_D: begin
                    if (axi.RVALID) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= axi.RDATA;
                        rsp_last_q  <= axi.RLAST;
                        rsp_err_q   <= rd_err_d;
                        cnt_q       <= cnt_q + 4'd1;
                        // RLAST is authoritative: a short or long burst still terminates here.
                        if (axi.RLAST) begin
                            rready_q    <= 1'b0;
                            req_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end
                WR_AW: begin
                    if (awvalid_q && axi.AWREADY) awvalid_q <= 1'b0;
                    if (wvalid_q && axi.WREADY)   wvalid_q  <= 1'b0;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_B;
                    end
                end
                WR_B: begin
                    if (axi.BVALID) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_last_q  <= 1'b1;
                        rsp_err_q   <= wr_err_d;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_last_o  = rsp_last_q;
    assign rsp_err_o   = rsp_err_q;

    assign axi.AWID    = MASTER_ID;
    assign axi.AWADDR  = addr_q;
    assign axi.AWLEN   = 4'd0;
    assign axi.AWSIZE  = 3'b010;
    assign axi.AWBURST = 2'b01;
    assign axi.AWVALID = awvalid_q;
    assign axi.WDATA   = wdata_q;
    assign axi.WSTRB   = wstrb_q;
    assign axi.WLAST   = 1'b1;
    assign axi.WVALID  = wvalid_q;
    assign axi.BREADY  = bready_q;
    assign axi.ARID    = MASTER_ID;
    assign axi.ARADDR  = addr_q;
    assign axi.ARLEN   = len_q;
    assign axi.ARSIZE  = 3'b010;
    assign axi.ARBURST = 2'b01;
    assign axi.ARVALID = arvalid_q;
    assign axi.RREADY  = rready_q;
endmodule

// File: tb/tb_axi_master_bridge.sv
// Directed + randomized bench for axi_master_bridge; the bench plays the AXI slave and
// predicts every bus payload and core response from the transaction-level rules.
module tb_axi_master_bridge;
    logic        clk, rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_len, req_wstrb;
    logic        rsp_valid, rsp_last, rsp_err;
    logic [31:0] rsp_rdata;

    int vectors     = 0;
    int miscompares = 0;
    int n_rsp       = 0;
    int exp_rsp     = 0;

    axi_master_bridge_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) bus ();

    axi_master_bridge #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .MASTER_ID(4'h0)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_len_i(req_len), .req_wdata_i(req_wdata),
        .req_wstrb_i(req_wstrb),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_last_o(rsp_last),
        .rsp_err_o(rsp_err),
        .axi(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rsp_valid === 1'b1) n_rsp++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Present a request when the bridge is ready, then scramble the inputs so only captured values matter.
    task automatic start_req(input bit wr, input logic [31:0] a, input logic [3:0] l,
                             input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        while (req_ready !== 1'b1 && n < 40) begin tick(); n++; end
        chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l;
        req_wdata = d;    req_wstrb = s;
        tick();
        req_valid = 1'b0; req_addr = $urandom; req_len = 4'($urandom);
        req_wdata = $urandom; req_wstrb = 4'($urandom);
        chk("req_ready_busy", {63'd0, req_ready}, 64'd0);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [1:0] rr, input logic [3:0] rid,
                             input bit lst, input bit eerr);
        bus.RVALID = 1'b1; bus.RDATA = d; bus.RRESP = rr; bus.RID = rid; bus.RLAST = lst;
        tick();
        bus.RVALID = 1'b0; bus.RLAST = 1'b0; bus.RDATA = $urandom;
        exp_rsp++;
        chk("rd_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("rd_rsp_rdata", {32'd0, rsp_rdata}, {32'd0, d});
        chk("rd_rsp_last",  {63'd0, rsp_last},  {63'd0, lst});
        chk("rd_rsp_err",   {63'd0, rsp_err},   {63'd0, eerr});
    endtask

    // Read of len+1 words; the slave raises RLAST on beat lb (lb != l models a malformed burst).
    task automatic do_read(input logic [31:0] a, input int l, input int lb, input int ar_dly,
                           input int gap, input bit rnd_err);
        logic [31:0] d;
        logic [1:0]  rr;
        logic [3:0]  rid;
        bit          lst, eerr;
        start_req(1'b0, a, 4'(l), 32'd0, 4'd0);
        chk("arvalid",  {63'd0, bus.ARVALID}, 64'd1);
        chk("araddr",   {32'd0, bus.ARADDR}, {32'd0, a & 32'hFFFF_FFFC});
        chk("arlen",    {60'd0, bus.ARLEN},  64'(l));
        chk("arsize",   {61'd0, bus.ARSIZE}, 64'd2);
        chk("arburst",  {62'd0, bus.ARBURST}, 64'd1);
        chk("arid",     {60'd0, bus.ARID},   64'd0);
        repeat (ar_dly) begin
            tick();
            chk("arvalid_hold", {63'd0, bus.ARVALID}, 64'd1);
            chk("araddr_hold",  {32'd0, bus.ARADDR}, {32'd0, a & 32'hFFFF_FFFC});
        end
        bus.ARREADY = 1'b1;
        tick();
        bus.ARREADY = 1'b0;
        chk("arvalid_drop", {63'd0, bus.ARVALID}, 64'd0);
        chk("rready_on",    {63'd0, bus.RREADY},  64'd1);
        for (int b = 0; b <= lb; b++) begin
            repeat (gap) begin
                tick();
                chk("rd_rsp_idle", {63'd0, rsp_valid},  64'd0);
                chk("rready_hold", {63'd0, bus.RREADY}, 64'd1);
            end
            d   = $urandom;
            rr  = (rnd_err && $urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rid = (rnd_err && $urandom_range(0, 7) == 0) ? 4'h3 : 4'h0;
            lst = (b == lb);
            eerr = (rr != 2'b00) || (rid != 4'h0) || (lst != (b == l));
            send_beat(d, rr, rid, lst, eerr);
        end
        chk("rd_end_req_ready", {63'd0, req_ready},  64'd1);
        chk("rd_end_rready",    {63'd0, bus.RREADY}, 64'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input logic [1:0] bresp, input logic [3:0] bid);
        int mx = (aw_dly > w_dly) ? aw_dly : w_dly;
        start_req(1'b1, a, 4'($urandom), d, s);
        chk("awvalid", {63'd0, bus.AWVALID}, 64'd1);
        chk("wvalid",  {63'd0, bus.WVALID},  64'd1);
        chk("awaddr",  {32'd0, bus.AWADDR}, {32'd0, a & 32'hFFFF_FFFC});
        chk("awlen",   {60'd0, bus.AWLEN},  64'd0);
        chk("awsize",  {61'd0, bus.AWSIZE}, 64'd2);
        chk("awburst", {62'd0, bus.AWBURST}, 64'd1);
        chk("wdata",   {32'd0, bus.WDATA},  {32'd0, d});
        chk("wstrb",   {60'd0, bus.WSTRB},  {60'd0, s});
        chk("wlast",   {63'd0, bus.WLAST},  64'd1);
        for (int c = 0; c <= mx; c++) begin
            bus.AWREADY = (c == aw_dly);
            bus.WREADY  = (c == w_dly);
            tick();
            chk("awvalid_seq", {63'd0, bus.AWVALID}, {63'd0, c < aw_dly});
            chk("wvalid_seq",  {63'd0, bus.WVALID},  {63'd0, c < w_dly});
            chk("bready_seq",  {63'd0, bus.BREADY},  {63'd0, c == mx});
            if (c < w_dly) chk("wdata_hold", {32'd0, bus.WDATA}, {32'd0, d});
        end
        bus.AWREADY = 1'b0; bus.WREADY = 1'b0;
        repeat (b_dly) begin
            tick();
            chk("bready_hold", {63'd0, bus.BREADY}, 64'd1);
            chk("wr_rsp_idle", {63'd0, rsp_valid},  64'd0);
        end
        bus.BVALID = 1'b1; bus.BRESP = bresp; bus.BID = bid;
        tick();
        bus.BVALID = 1'b0;
        exp_rsp++;
        chk("wr_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("wr_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        chk("wr_rsp_last",  {63'd0, rsp_last},  64'd1);
        chk("wr_rsp_err",   {63'd0, rsp_err},   {63'd0, (bresp != 2'b00) || (bid != 4'h0)});
        chk("wr_end_req_ready", {63'd0, req_ready},  64'd1);
        chk("wr_end_bready",    {63'd0, bus.BREADY}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        req_wdata = '0;   req_wstrb = '0;
        bus.AWREADY = 1'b0; bus.WREADY = 1'b0;
        bus.BVALID = 1'b0;  bus.BRESP = 2'b00; bus.BID = 4'h0;
        bus.ARREADY = 1'b0;
        bus.RVALID = 1'b0;  bus.RDATA = '0; bus.RRESP = 2'b00; bus.RID = 4'h0; bus.RLAST = 1'b0;
        tick(); tick();
        chk("rst_req_ready", {63'd0, req_ready},   64'd1);
        chk("rst_arvalid",   {63'd0, bus.ARVALID}, 64'd0);
        chk("rst_awvalid",   {63'd0, bus.AWVALID}, 64'd0);
        chk("rst_wvalid",    {63'd0, bus.WVALID},  64'd0);
        chk("rst_rready",    {63'd0, bus.RREADY},  64'd0);
        chk("rst_bready",    {63'd0, bus.BREADY},  64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid},   64'd0);
        chk("rst_rsp_rdata", {32'd0, rsp_rdata},   64'd0);
        chk("rst_araddr",    {32'd0, bus.ARADDR},  64'd0);
        rst = 1'b0;
        tick();

        // Single-word read.
        do_read(32'h0000_1004, 0, 0, 0, 0, 1'b0);
        // Burst of 4 with ARREADY stall and 2-cycle RVALID gaps.
        do_read(32'h0000_2000, 3, 3, 2, 2, 1'b0);
        // Write with AWREADY one cycle ahead of WREADY.
        do_write(32'h0000_3008, 32'h55AA_00FF, 4'b0011, 0, 1, 1, 2'b00, 4'h0);
        // SLVERR and foreign BID.
        do_write(32'h0000_300C, 32'h1234_5678, 4'b1111, 1, 0, 0, 2'b10, 4'h0);
        do_write(32'h0000_3010, 32'hCAFE_F00D, 4'b1000, 0, 0, 0, 2'b00, 4'h5);
        // Early RLAST on beat 1 of a 4-beat burst; bridge must return to IDLE.
        do_read(32'h0000_4000, 3, 1, 0, 0, 1'b0);
        // Late RLAST: slave sends 3 beats for a 2-beat burst.
        do_read(32'h0000_4100, 1, 2, 0, 1, 1'b0);
        // Back-to-back: write, then read right after the bubble.
        do_write(32'h0000_5003, 32'hA5A5_5A5A, 4'b0101, 2, 2, 0, 2'b00, 4'h0);
        do_read(32'h0000_5003, 15, 15, 0, 0, 1'b0);

        // Reset in the middle of a read burst.
        start_req(1'b0, 32'h0000_6000, 4'd3, 32'd0, 4'd0);
        bus.ARREADY = 1'b1;
        tick();
        bus.ARREADY = 1'b0;
        send_beat(32'h1111_0000, 2'b00, 4'h0, 1'b0, 1'b0);
        send_beat(32'h2222_0000, 2'b00, 4'h0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk("midrst_arvalid",   {63'd0, bus.ARVALID}, 64'd0);
        chk("midrst_rready",    {63'd0, bus.RREADY},  64'd0);
        chk("midrst_rsp_valid", {63'd0, rsp_valid},   64'd0);
        chk("midrst_req_ready", {63'd0, req_ready},   64'd1);
        rst = 1'b0;
        do_read(32'h0000_6040, 2, 2, 1, 0, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_write($urandom, $urandom, 4'($urandom), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3),
                         ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                         ($urandom_range(0, 7) == 0) ? 4'h9 : 4'h0);
            end else begin
                int l;
                int lb;
                l  = $urandom_range(0, 15);
                lb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : l;
                do_read($urandom, l, lb, $urandom_range(0, 3), $urandom_range(0, 2), 1'b1);
            end
        end

        tick(); tick();
        chk("rsp_pulse_count", 64'(n_rsp), 64'(exp_rsp));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
